// File: rtl/penguen_pkg.sv
// Shared definitions for the penguin race: controller states and default widths.
package penguen_pkg;

   localparam int DEF_BALIK_W = 3;
   localparam int DEF_HEDEF_W = 6;
   localparam int DEF_SURE_W  = 7;

   typedef enum logic [2:0] {
      BOS,
      YARIS,
      TARA,
      BOL,
      SONUC
   } durum_t;

endpackage

// File: rtl/penguen_kanal.sv
// One penguin channel: fish accumulator, finish timer, finish and timeout detect.
module penguen_kanal
   import penguen_pkg::*;
#(
   parameter int BALIK_W = DEF_BALIK_W,
   parameter int HEDEF_W = DEF_HEDEF_W,
   parameter int SURE_W  = DEF_SURE_W
) (
   input  logic               saat,
   input  logic               reset,
   input  logic               temizle,
   input  logic               aktif,
   input  logic [HEDEF_W-1:0] hedef,
   input  logic [BALIK_W-1:0] balik,
   output logic               bitiyor,
   output logic               bitti,
   output logic               zaman_asimi,
   output logic [SURE_W-1:0]  sure
);

   logic [HEDEF_W-1:0] acc_q, acc_d;
   logic [SURE_W-1:0]  sure_q, sure_d;
   logic               done_q, done_d;
   logic               asim_q, asim_d;
   logic [HEDEF_W:0]   toplam;

   // Next channel state: clear on start, otherwise count while racing and unfinished.
   // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      acc_d  = acc_q;
      sure_d = sure_q;
      done_d = done_q;
      asim_d = asim_q;
      toplam = {1'b0, acc_q} + (HEDEF_W+1)'(balik);
      if (temizle) begin
         acc_d  = '0;
         sure_d = '0;
         done_d = 1'b0;
         asim_d = 1'b0;
      end else if (aktif && !done_q) begin
         acc_d  = toplam[HEDEF_W] ? '1 : toplam[HEDEF_W-1:0];
         sure_d = sure_q + SURE_W'(1);
         if (toplam >= {1'b0, hedef}) begin
            done_d = 1'b1;
         end else if (&sure_d) begin
            // Timer hit its ceiling without reaching the target: forced finish.
            done_d = 1'b1;
            asim_d = 1'b1;
         end
      end
   end

   // Channel state registers.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         acc_q  <= '0;
         sure_q <= '0;
         done_q <= 1'b0;
         asim_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         sure_q <= sure_d;
         done_q <= done_d;
         asim_q <= asim_d;
      end
   end

   // bitiyor is the finish flag as it will be after this edge, so the
   // controller can leave the race in the same cycle the last penguin finishes.
   assign bitiyor     = done_d;
   assign bitti       = done_q;
   assign zaman_asimi = asim_q;
   assign sure        = sure_q;

endmodule

// File: rtl/penguen_yarisi.sv
// Penguin race: N fish-catching channels, then a shared min/max/sum scan and a
// serial restoring divider producing the mean finish time.
module penguen_yarisi
   import penguen_pkg::*;
#(
   parameter int  N_PENGUEN = 5,
   parameter int  BALIK_W   = DEF_BALIK_W,
   parameter int  HEDEF_W   = DEF_HEDEF_W,
   parameter int  SURE_W    = DEF_SURE_W,
   localparam int IDX_W     = $clog2(N_PENGUEN + 1),
   localparam int TOPLAM_W  = SURE_W + $clog2(N_PENGUEN)
) (
   input  logic                         saat,
   input  logic                         reset,
   input  logic                         basla,
   input  logic [HEDEF_W-1:0]           hedef,
   input  logic [N_PENGUEN*BALIK_W-1:0] avlanan_balik,
   output logic                         mesgul,
   output logic                         bitti,
   output logic [SURE_W-1:0]            en_kisa,
   output logic [SURE_W-1:0]            en_uzun,
   output logic [SURE_W-1:0]            ortalama,
   output logic [IDX_W-1:0]             hizli_penguen,
   output logic [IDX_W-1:0]             yavas_penguen,
   output logic                         zaman_asimi,
   output logic [N_PENGUEN-1:0]         bitiren_maske
);

   localparam int SEL_W = $clog2(N_PENGUEN);
   localparam int CNT_W = $clog2(TOPLAM_W + N_PENGUEN + 1);

   durum_t              durum_q, durum_d;
   logic [HEDEF_W-1:0]  hedef_q, hedef_d;
   logic [CNT_W-1:0]    sayac_q, sayac_d;
   logic [SURE_W-1:0]   min_q, min_d, max_q, max_d;
   logic [IDX_W-1:0]    hizli_q, hizli_d, yavas_q, yavas_d;
   logic [TOPLAM_W-1:0] toplam_q, toplam_d;   // scan sum, then divider shift register
   logic [IDX_W-1:0]    kalan_q, kalan_d;     // divider partial remainder
   logic [IDX_W:0]      kalan_kay;
   logic                temizle, aktif;

   logic [N_PENGUEN-1:0] bitiyor, bitti_v, asim_v;
   logic [SURE_W-1:0]    sure_v [N_PENGUEN];
   logic [SURE_W-1:0]    tarama;

   for (genvar g = 0; g < N_PENGUEN; g++) begin : g_kanal
      penguen_kanal #(
         .BALIK_W (BALIK_W),
         .HEDEF_W (HEDEF_W),
         .SURE_W  (SURE_W)
      ) u_kanal (
         .saat        (saat),
         .reset       (reset),
         .temizle     (temizle),
         .aktif       (aktif),
         .hedef       (hedef_q),
         .balik       (avlanan_balik[g*BALIK_W +: BALIK_W]),
         .bitiyor     (bitiyor[g]),
         .bitti       (bitti_v[g]),
         .zaman_asimi (asim_v[g]),
         .sure        (sure_v[g])
      );
   end

   // The single shared scan port: one channel time per TARA cycle.
   assign tarama    = sure_v[sayac_q[SEL_W-1:0]];
   assign kalan_kay = {kalan_q, toplam_q[TOPLAM_W-1]};

   // Controller next-state and datapath updates.
   always_comb begin
      durum_d  = durum_q;
      hedef_d  = hedef_q;
      sayac_d  = sayac_q;
      min_d    = min_q;
      max_d    = max_q;
      hizli_d  = hizli_q;
      yavas_d  = yavas_q;
      toplam_d = toplam_q;
      kalan_d  = kalan_q;
      temizle  = 1'b0;
      aktif    = 1'b0;
      case (durum_q)
         BOS, SONUC: begin
            if (basla) begin
               temizle  = 1'b1;
               hedef_d  = hedef;
               sayac_d  = '0;
               min_d    = '0;
               max_d    = '0;
               hizli_d  = '0;
               yavas_d  = '0;
               toplam_d = '0;
               kalan_d  = '0;
               durum_d  = YARIS;
            end
         end
         YARIS: begin
            aktif = 1'b1;
            if (&bitiyor) begin
               sayac_d = '0;
               durum_d = TARA;
            end
         end
         TARA: begin
            // Strict compares keep the lowest index on ties; the first visit seeds both.
            if (sayac_q == '0 || tarama < min_q) begin
               min_d   = tarama;
               hizli_d = IDX_W'(sayac_q) + IDX_W'(1);
            end
            if (sayac_q == '0 || tarama > max_q) begin
               max_d   = tarama;
               yavas_d = IDX_W'(sayac_q) + IDX_W'(1);
            end
            toplam_d = toplam_q + TOPLAM_W'(tarama);
            if (sayac_q == CNT_W'(N_PENGUEN - 1)) begin
               sayac_d = '0;
               durum_d = BOL;
            end else begin
               sayac_d = sayac_q + CNT_W'(1);
            end
         end
         BOL: begin
            // Restoring division: quotient bits shift in where dividend bits leave.
            if (kalan_kay >= (IDX_W+1)'(N_PENGUEN)) begin
               kalan_d  = IDX_W'(kalan_kay - (IDX_W+1)'(N_PENGUEN));
               toplam_d = {toplam_q[TOPLAM_W-2:0], 1'b1};
            end else begin
               kalan_d  = kalan_kay[IDX_W-1:0];
               toplam_d = {toplam_q[TOPLAM_W-2:0], 1'b0};
            end
            if (sayac_q == CNT_W'(TOPLAM_W - 1)) begin
               sayac_d = '0;
               durum_d = SONUC;
            end else begin
               sayac_d = sayac_q + CNT_W'(1);
            end
         end
         default: durum_d = BOS;
      endcase
   end

   // Controller and shared datapath registers.
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         durum_q  <= BOS;
         hedef_q  <= '0;
         sayac_q  <= '0;
         min_q    <= '0;
         max_q    <= '0;
         hizli_q  <= '0;
         yavas_q  <= '0;
         toplam_q <= '0;
         kalan_q  <= '0;
      end else begin
         durum_q  <= durum_d;
         hedef_q  <= hedef_d;
         sayac_q  <= sayac_d;
         min_q    <= min_d;
         max_q    <= max_d;
         hizli_q  <= hizli_d;
         yavas_q  <= yavas_d;
         toplam_q <= toplam_d;
         kalan_q  <= kalan_d;
      end
   end

   // Results are only presented in SONUC; elsewhere they read as zero.
   assign mesgul        = (durum_q == YARIS) || (durum_q == TARA) || (durum_q == BOL);
   assign bitti         = (durum_q == SONUC);
   assign en_kisa       = bitti ? min_q : '0;
   assign en_uzun       = bitti ? max_q : '0;
   assign ortalama      = bitti ? toplam_q[SURE_W-1:0] : '0;
   assign hizli_penguen = bitti ? hizli_q : '0;
   assign yavas_penguen = bitti ? yavas_q : '0;
   assign zaman_asimi   = bitti & (|asim_v);
   assign bitiren_maske = bitti_v;

endmodule

// File: tb/tb_penguen_yarisi.sv
// Self-checking bench for penguen_yarisi against a per-channel arithmetic race model.
module tb_penguen_yarisi;

   localparam int N     = 5;
   localparam int BW    = 3;
   localparam int HW    = 6;
   localparam int SW    = 7;
   localparam int IW    = $clog2(N + 1);
   localparam int TW    = SW + $clog2(N);
   localparam int TMAXV = (1 << SW) - 1;

   logic            saat = 1'b0;
   logic            reset = 1'b0;
   logic            basla = 1'b0;
   logic [HW-1:0]   hedef = '0;
   logic [N*BW-1:0] avlanan_balik = '0;
   logic            mesgul, bitti, zaman_asimi;
   logic [SW-1:0]   en_kisa, en_uzun, ortalama;
   logic [IW-1:0]   hizli_penguen, yavas_penguen;
   logic [N-1:0]    bitiren_maske;

   int checks = 0;
   int errors = 0;

   int fish_tab [1:TMAXV][N];
   int m_time [N];
   int m_min, m_max, m_fast, m_slow, m_avg, m_to, m_tmax;
   int h_keep;

   penguen_yarisi #(.N_PENGUEN(N), .BALIK_W(BW), .HEDEF_W(HW), .SURE_W(SW)) dut (
      .saat          (saat),
      .reset         (reset),
      .basla         (basla),
      .hedef         (hedef),
      .avlanan_balik (avlanan_balik),
      .mesgul        (mesgul),
      .bitti         (bitti),
      .en_kisa       (en_kisa),
      .en_uzun       (en_uzun),
      .ortalama      (ortalama),
      .hizli_penguen (hizli_penguen),
      .yavas_penguen (yavas_penguen),
      .zaman_asimi   (zaman_asimi),
      .bitiren_maske (bitiren_maske)
   );

   always #5 saat = ~saat;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Race model: each channel finishes at the first cycle its running catch
   // reaches the target, or at the timer ceiling if it never does.
   function automatic void model(input int h);
      int s;
      int sum_t;
      int q[$];
      sum_t = 0;
      m_to  = 0;
      for (int k = 0; k < N; k++) begin
         s = 0;
         m_time[k] = TMAXV;
         for (int t = 1; t <= TMAXV; t++) begin
            s += fish_tab[t][k];
            if (s >= h) begin
               m_time[k] = t;
               break;
            end
         end
         if (s < h) m_to = 1;
         sum_t += m_time[k];
      end
      q = m_time.min();
      m_min = q[0];
      q = m_time.max();
      m_max = q[0];
      m_tmax = m_max;
      q = m_time.find_first_index(x) with (x == m_min);
      m_fast = q[0] + 1;
      q = m_time.find_first_index(x) with (x == m_max);
      m_slow = q[0] + 1;
      m_avg = sum_t / N;
   endfunction

   function automatic logic [N-1:0] mask_exp(input int t);
      logic [N-1:0] m;
      for (int k = 0; k < N; k++) m[k] = (m_time[k] <= t);
      return m;
   endfunction

   function automatic logic [N*BW-1:0] pack_row(input int t);
      logic [N*BW-1:0] v;
      v = '0;
      if (t >= 1 && t <= TMAXV)
         for (int k = 0; k < N; k++) v[k*BW +: BW] = BW'(fish_tab[t][k]);
      return v;
   endfunction

   task automatic fill_const(input int f [N]);
      for (int t = 1; t <= TMAXV; t++)
         for (int k = 0; k < N; k++) fish_tab[t][k] = f[k];
   endtask

   task automatic fill_rand();
      int lim [N];
      for (int k = 0; k < N; k++) lim[k] = $urandom_range(7, 0);
      for (int t = 1; t <= TMAXV; t++)
         for (int k = 0; k < N; k++) fish_tab[t][k] = $urandom_range(lim[k], 0);
   endtask

   task automatic check_all_zero(input string ad);
      check({ad, " mesgul"}, mesgul, 0);
      check({ad, " bitti"}, bitti, 0);
      check({ad, " en_kisa"}, en_kisa, 0);
      check({ad, " en_uzun"}, en_uzun, 0);
      check({ad, " ortalama"}, ortalama, 0);
      check({ad, " hizli"}, hizli_penguen, 0);
      check({ad, " yavas"}, yavas_penguen, 0);
      check({ad, " zaman_asimi"}, zaman_asimi, 0);
      check({ad, " maske"}, bitiren_maske, 0);
   endtask

   // One race: start, feed fish cycle by cycle, track the finish mask, and
   // check timing and results. t counts rising edges since basla was taken.
   task automatic run_race(input string ad, input int h, input bit pulses, input bit abort_bol);
      int t;
      bit done;
      model(h);
      @(negedge saat);
      basla = 1'b1;
      hedef = HW'(h);
      avlanan_balik = pack_row(1);
      @(posedge saat);
      t = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge saat);
         if (t > 0) begin
            check({ad, " maske"}, bitiren_maske, mask_exp(t));
            if (t == 1) begin
               check({ad, " mesgul start"}, mesgul, 1);
               check({ad, " bitti start"}, bitti, 0);
            end
            if (bitti) begin
               check({ad, " latency"}, t, m_tmax + N + TW);
               check({ad, " en_kisa"}, en_kisa, m_min);
               check({ad, " en_uzun"}, en_uzun, m_max);
               check({ad, " ortalama"}, ortalama, m_avg);
               check({ad, " hizli"}, hizli_penguen, m_fast);
               check({ad, " yavas"}, yavas_penguen, m_slow);
               check({ad, " zaman_asimi"}, zaman_asimi, m_to);
               check({ad, " mesgul end"}, mesgul, 0);
               done = 1'b1;
            end else if (abort_bol && t == m_tmax + N + 3) begin
               reset = 1'b0;
               #1;
               check_all_zero({ad, " async reset"});
               #2;
               reset = 1'b1;
               done = 1'b1;
            end else if (t > m_tmax + N + TW + 8) begin
               check({ad, " bitti never rose"}, bitti, 1);
               done = 1'b1;
            end
         end
         if (!done) begin
            basla = pulses && (t + 1 == 2 || t + 1 == m_tmax || t + 1 == m_tmax + 2);
            avlanan_balik = pack_row(t + 1);
            @(posedge saat);
            t++;
         end
      end
      basla = 1'b0;
      avlanan_balik = '0;
   endtask

   initial begin
      repeat (3) @(posedge saat);
      @(negedge saat);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (3) @(negedge saat);
      check("idle mesgul", mesgul, 0);
      check("idle bitti", bitti, 0);

      fill_const('{1, 2, 3, 4, 5});
      run_race("farkli", 10, 1'b0, 1'b0);

      fill_const('{2, 2, 2, 2, 2});
      run_race("esit", 10, 1'b0, 1'b0);

      fill_const('{1, 1, 0, 1, 1});
      run_race("asim", 10, 1'b0, 1'b0);

      fill_const('{3, 0, 7, 1, 5});
      run_race("hedef0", 0, 1'b0, 1'b0);

      fill_const('{1, 2, 3, 4, 5});
      run_race("basla_darbe", 10, 1'b1, 1'b0);

      fill_rand();
      h_keep = $urandom_range(63, 1);
      run_race("bol_reset", h_keep, 1'b0, 1'b1);
      repeat (3) @(negedge saat);
      check("post reset mesgul", mesgul, 0);
      check("post reset bitti", bitti, 0);
      run_race("reset_sonrasi", h_keep, 1'b0, 1'b0);

      repeat (6) begin
         fill_rand();
         run_race("rastgele", $urandom_range(63, 1), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
